// File: rtl/eth_idma_pkg.sv
// Shared types for the Ethernet iDMA launcher: launch request record, direction,
// AXI response codes and launcher FSM states.
package eth_idma_pkg;

  localparam int unsigned ReqAddrWidth = 32;
  localparam int unsigned ReqLenWidth  = 32;

  typedef enum logic {
    DIR_TX = 1'b0,  // AXI -> AXIS
    DIR_RX = 1'b1   // AXIS -> AXI
  } dir_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ReqLenWidth-1:0]  len;
    logic [ReqAddrWidth-1:0] src;
    logic [ReqAddrWidth-1:0] dst;
    dir_e                    dir;
  } launch_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/eth_idma_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module eth_idma_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_idma_launcher.sv
// iDMA request initiator: launch capture, backend request handshake, response accounting.
// Optional first-error capture enabled by defining ETH_IDMA_LAUNCHER_ERR_LOG_EN.
module eth_idma_launcher
  import eth_idma_pkg::*;
#(
  parameter int unsigned AddrWidth      = ReqAddrWidth,
  parameter int unsigned TFLenWidth     = ReqLenWidth,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = 16,
  localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  launch_valid_i,
  output logic                  launch_ready_o,
  input  logic [TFLenWidth-1:0] launch_len_i,
  input  logic [AddrWidth-1:0]  launch_src_i,
  input  logic [AddrWidth-1:0]  launch_dst_i,
  input  logic                  launch_dir_i,
  output logic                  idma_req_valid_o,
  input  logic                  idma_req_ready_i,
  output logic [TFLenWidth-1:0] idma_req_len_o,
  output logic [AddrWidth-1:0]  idma_req_src_o,
  output logic [AddrWidth-1:0]  idma_req_dst_o,
  output logic                  idma_req_dir_o,
  input  logic                  idma_rsp_valid_i,
  output logic                  idma_rsp_ready_o,
  input  logic                  idma_rsp_error_i,
  input  logic [AddrWidth-1:0]  idma_rsp_addr_i,
  input  logic [1:0]            idma_rsp_cause_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic [OutW-1:0]       outstanding_o,
  output logic [CntWidth-1:0]   done_cnt_o,
  output logic [CntWidth-1:0]   err_cnt_o,
  output logic                  spurious_o,
  output logic                  irq_o,
  output logic [AddrWidth-1:0]  err_addr_o,
  output logic [1:0]            err_cause_o,
  output logic                  err_valid_o
);

  // The request register is the package struct, so its widths must match.
  if (AddrWidth != ReqAddrWidth || TFLenWidth != ReqLenWidth) begin : g_width_check
    $error("eth_idma_launcher: AddrWidth/TFLenWidth must match eth_idma_pkg");
  end

  state_e          state_q;
  launch_req_t     req_q;
  logic [OutW-1:0] out_q, out_d;
  logic            irq_q, spur_q;
  logic            launch_hs, req_hs, rsp_acc;

  assign launch_ready_o   = (state_q == IDLE) && (out_q < OutW'(MaxOutstanding));
  assign launch_hs        = launch_valid_i && launch_ready_o;
  assign req_hs           = (state_q == ISSUE) && idma_req_ready_i;
  assign rsp_acc          = idma_rsp_valid_i && (out_q != '0);
  assign idma_rsp_ready_o = ~rst_i;

  always_comb begin
    out_d = out_q;
    if (req_hs && !rsp_acc) begin
      out_d = out_q + OutW'(1);
    end else if (!req_hs && rsp_acc) begin
      out_d = out_q - OutW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (launch_hs) begin
          req_q   <= '{len: launch_len_i, src: launch_src_i, dst: launch_dst_i,
                       dir: dir_e'(launch_dir_i)};
          state_q <= ISSUE;
        end
        ISSUE: if (idma_req_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses with nothing in flight are flagged, never counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= '0;
      irq_q  <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      out_q <= out_d;
      irq_q <= rsp_acc;
      if (clr_i) begin
        spur_q <= 1'b0;
      end else if (idma_rsp_valid_i && (out_q == '0)) begin
        spur_q <= 1'b1;
      end
    end
  end

  eth_idma_sat_cnt #(.Width(CntWidth)) u_done_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (rsp_acc),
    .cnt_o (done_cnt_o)
  );

  eth_idma_sat_cnt #(.Width(CntWidth)) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (rsp_acc && idma_rsp_error_i),
    .cnt_o (err_cnt_o)
  );

`ifdef ETH_IDMA_LAUNCHER_ERR_LOG_EN
  logic                 err_valid_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic [1:0]           err_cause_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= '0;
    end else if (rsp_acc && idma_rsp_error_i && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= idma_rsp_addr_i;
      err_cause_q <= idma_rsp_cause_i;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_cause_o = err_cause_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{idma_rsp_addr_i, idma_rsp_cause_i};
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_cause_o = '0;
`endif

  assign idma_req_valid_o = (state_q == ISSUE);
  assign idma_req_len_o   = req_q.len;
  assign idma_req_src_o   = req_q.src;
  assign idma_req_dst_o   = req_q.dst;
  assign idma_req_dir_o   = req_q.dir;
  assign busy_o           = (state_q == ISSUE) || (out_q != '0);
  assign outstanding_o    = out_q;
  assign irq_o            = irq_q;
  assign spurious_o       = spur_q;

endmodule
